// File: rtl/sync_counter_ctrl.sv
// Loadable up/down modulus counter with run/hold/one-shot control. It also
// drives J/K toggle vectors so an external JK flip-flop bank can track the count.
module sync_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             halt,
    input  logic             up,
    input  logic             mode,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] step_val;

    // A count outside 0..modulus (modulus lowered mid-run) folds back into range.
    always_comb begin
        if (up)
            step_val = (count >= modulus) ? '0 : count + ONE;
        else
            step_val = (count == '0 || count > modulus) ? modulus : count - ONE;
    end

    assign tc = (state == RUN) && (up ? (count >= modulus) : (count == '0));

    always_comb begin
        state_d = state;
        count_d = count;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
            count_d = up ? '0 : modulus;
        end else begin
            unique case (state)
                IDLE: ;
                RUN: begin
                    if (halt)
                        state_d = HOLD;
                    else if (mode && tc)
                        state_d = DONE;
                    else
                        count_d = step_val;
                end
                HOLD: if (!halt) state_d = RUN;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Toggle vector is taken from the count that will actually be registered.
    assign j    = (state == RUN) ? (count ^ count_d) : '0;
    assign k    = j;
    assign busy = (state == RUN) || (state == HOLD);
    assign done = (state == DONE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end

endmodule
